// File: rtl/sm_slice_scheduler.sv
// rtl/sm_slice_scheduler.sv - time-slice scheduler rotating the SM pipeline over resident contexts
// Optional drain watchdog enabled by defining SM_DRAIN_WDOG_EN.
module sm_slice_scheduler #(
    parameter int N_CTX      = 8,
    parameter int CTX_LOG    = 3,
    parameter int GRAN_W     = 16,
    parameter int WAIT_LIMIT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               en_i,
    input  logic [N_CTX-1:0]   ctx_mask_i,
    input  logic [GRAN_W-1:0]  granu_i,
    input  logic               branch_i,
    input  logic               issuedbranch_i,
    input  logic               reconv_i,
    input  logic               lsuStallFront_i,
    input  logic               frontendLdSt_i,
    input  logic               issuedLdSt_i,
    input  logic               fuLdSt_i,
    input  logic               aguLdSt_i,
    input  logic               swapDone_i,
    output logic               swap_req_o,
    output logic [CTX_LOG-1:0] swap_from_o,
    output logic [CTX_LOG-1:0] swap_to_o,
    output logic [CTX_LOG-1:0] sm_o,
    output logic               fetch_hold_o,
    output logic               stallRun_o,
    output logic               drain_timeout_o
);

    localparam int IW = CTX_LOG + 1;

    if ((1 << CTX_LOG) < N_CTX || N_CTX < 2 || WAIT_LIMIT < 1) begin : g_bad_param
        $error("sm_slice_scheduler: inconsistent N_CTX/CTX_LOG/WAIT_LIMIT");
    end

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP} state_t;

    state_t              state_q;
    logic [GRAN_W-1:0]   cnt_q;
    logic [CTX_LOG-1:0]  sm_q;
    logic [CTX_LOG-1:0]  to_q;
    logic                req_q;
    logic                stall_run_q;
    logic                hold_q;

    logic                not_bra_rcv;
    logic                not_ld_st;
    logic                safe;
    logic                drain_enter;

    assign not_bra_rcv = ~reconv_i & ~issuedbranch_i & ~branch_i;
    assign not_ld_st   = lsuStallFront_i ? (~issuedLdSt_i & ~fuLdSt_i & ~aguLdSt_i)
                                         : (~frontendLdSt_i & ~issuedLdSt_i & ~fuLdSt_i);
    assign safe        = not_bra_rcv & not_ld_st;
    assign drain_enter = (state_q == ST_RUN) && en_i && !stall_i && !(cnt_q < granu_i);

    // Doubling the mask turns the wrapped search into a plain right shift starting at sm+1.
    logic [2*N_CTX-1:0]  mask_dbl;
    logic [N_CTX-1:0]    rot;
    logic [IW-1:0]       base;
    logic [IW-1:0]       cand;
    logic                found;
    logic [CTX_LOG-1:0]  next_ctx;

    always_comb begin
        mask_dbl = {ctx_mask_i, ctx_mask_i};
        base     = {1'b0, sm_q} + IW'(1);
        rot      = N_CTX'(mask_dbl >> base);
        cand     = '0;
        found    = 1'b0;
        next_ctx = sm_q;
        for (int j = 0; j < N_CTX; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                cand  = base + IW'(j);
                if (cand >= IW'(N_CTX)) begin
                    cand = cand - IW'(N_CTX);
                end
                next_ctx = cand[CTX_LOG-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            sm_q        <= '0;
            to_q        <= '0;
            req_q       <= 1'b0;
            stall_run_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!en_i) begin
                        cnt_q <= '0;
                    end else if (drain_enter) begin
                        state_q <= ST_DRAIN;
                        hold_q  <= 1'b1;
                    end else if (!stall_i) begin
                        cnt_q <= cnt_q + GRAN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!stall_i && safe) begin
                        if (next_ctx == sm_q) begin
                            cnt_q   <= '0;
                            hold_q  <= 1'b0;
                            state_q <= ST_RUN;
                        end else begin
                            to_q        <= next_ctx;
                            req_q       <= 1'b1;
                            stall_run_q <= 1'b1;
                            state_q     <= ST_SWAP;
                        end
                    end
                end
                ST_SWAP: begin
                    if (swapDone_i) begin
                        sm_q        <= to_q;
                        cnt_q       <= '0;
                        req_q       <= 1'b0;
                        stall_run_q <= 1'b0;
                        hold_q      <= 1'b0;
                        state_q     <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

`ifdef SM_DRAIN_WDOG_EN
    localparam int WD_W = $clog2(WAIT_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            timeout_q;

    // Counts stalled DRAIN cycles too; saturates so the flag cannot be re-armed by wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (drain_enter) begin
            wd_cnt_q <= '0;
        end else if (state_q == ST_DRAIN) begin
            if (wd_cnt_q != WD_W'(WAIT_LIMIT)) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (wd_cnt_q >= WD_W'(WAIT_LIMIT - 1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign drain_timeout_o = timeout_q;
`else
    assign drain_timeout_o = 1'b0;
`endif

    assign swap_req_o   = req_q;
    assign swap_from_o  = sm_q;
    assign swap_to_o    = to_q;
    assign sm_o         = sm_q;
    assign fetch_hold_o = hold_q;
    assign stallRun_o   = stall_run_q;

endmodule

// File: tb/tb_sm_slice_scheduler.sv
// tb/tb_sm_slice_scheduler.sv - self-checking bench for sm_slice_scheduler (4- and 5-context instances)
module tb_sm_slice_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, en, br, ibr, rcv, lsf, fel, ildst, fu, agu, done;
    logic [4:0]  mask;
    logic [15:0] granu;

    logic        a_req, a_hold, a_srun, a_tmo;
    logic [1:0]  a_from, a_to, a_sm;
    logic        b_req, b_hold, b_srun, b_tmo;
    logic [2:0]  b_from, b_to, b_sm;

    sm_slice_scheduler #(.N_CTX(4), .CTX_LOG(2), .GRAN_W(16), .WAIT_LIMIT(16)) u_dut4 (
        .clk(clk), .reset(reset), .stall_i(stall), .en_i(en), .ctx_mask_i(mask[3:0]),
        .granu_i(granu), .branch_i(br), .issuedbranch_i(ibr), .reconv_i(rcv),
        .lsuStallFront_i(lsf), .frontendLdSt_i(fel), .issuedLdSt_i(ildst), .fuLdSt_i(fu),
        .aguLdSt_i(agu), .swapDone_i(done), .swap_req_o(a_req), .swap_from_o(a_from),
        .swap_to_o(a_to), .sm_o(a_sm), .fetch_hold_o(a_hold), .stallRun_o(a_srun),
        .drain_timeout_o(a_tmo));

    sm_slice_scheduler #(.N_CTX(5), .CTX_LOG(3), .GRAN_W(16), .WAIT_LIMIT(16)) u_dut5 (
        .clk(clk), .reset(reset), .stall_i(stall), .en_i(en), .ctx_mask_i(mask),
        .granu_i(granu), .branch_i(br), .issuedbranch_i(ibr), .reconv_i(rcv),
        .lsuStallFront_i(lsf), .frontendLdSt_i(fel), .issuedLdSt_i(ildst), .fuLdSt_i(fu),
        .aguLdSt_i(agu), .swapDone_i(done), .swap_req_o(b_req), .swap_from_o(b_from),
        .swap_to_o(b_to), .sm_o(b_sm), .fetch_hold_o(b_hold), .stallRun_o(b_srun),
        .drain_timeout_o(b_tmo));

    int n_chk  = 0;
    int n_fail = 0;
    bit auto_resp = 0;
    int req_age = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // One clock; optionally plays the swap engine on the 4-context instance (done 2 cycles after req).
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_resp) begin
            if (a_req) begin
                req_age++;
                done = (req_age >= 2);
            end else begin
                req_age = 0;
                done = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_age = 0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_sm(input logic [1:0] v, input string name);
        int k = 0;
        while (a_sm !== v && k < 200) begin tick(); k++; end
        check(name, a_sm, v);
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (a_req !== 1'b1 && k < 200) begin tick(); k++; end
        check(name, a_req, 1);
    endtask

    function automatic bit safe_f();
        bit branchy = br | ibr | rcv;
        bit ldst    = lsf ? (ildst | fu | agu) : (fel | ildst | fu);
        return !branchy && !ldst;
    endfunction

    function automatic int next_f(int cur, logic [4:0] m, int n);
        for (int i = 1; i <= n; i++) begin
            if (m[(cur + i) % n]) return (cur + i) % n;
        end
        return cur;
    endfunction

    typedef struct {
        logic [3:0] mask;
        logic [7:0] occ;
        logic       exp_req;
        logic [1:0] exp_to;
        logic       exp_hold;
    } vec_t;
    vec_t vec [16];

    int m_ph, m_cnt, m_sm, m_to, m_dc, m_tmo;
    int fh, first_req, first_to, srun_bad, nreq, nhold, ntmo, bad;
    int smq [$];
    logic [1:0] last_sm;
    logic [12:0] got_v, exp_v;

    initial begin
        reset = 1'b1; stall = 0; en = 1; mask = 5'b01111; granu = 16'd3; done = 0;
        {br, ibr, rcv, lsf, fel, ildst, fu, agu} = 8'b0;

        vec[0]  = '{4'b1111, 8'b0000_0000, 1'b1, 2'd1, 1'b1};
        vec[1]  = '{4'b1000, 8'b0000_0000, 1'b1, 2'd3, 1'b1};
        vec[2]  = '{4'b0100, 8'b0000_0000, 1'b1, 2'd2, 1'b1};
        vec[3]  = '{4'b0001, 8'b0000_0000, 1'b0, 2'd0, 1'b0};
        vec[4]  = '{4'b0000, 8'b0000_0000, 1'b0, 2'd0, 1'b0};
        vec[5]  = '{4'b1111, 8'b1000_0000, 1'b0, 2'd0, 1'b1};
        vec[6]  = '{4'b1111, 8'b0100_0000, 1'b0, 2'd0, 1'b1};
        vec[7]  = '{4'b1111, 8'b0010_0000, 1'b0, 2'd0, 1'b1};
        vec[8]  = '{4'b1111, 8'b0000_1000, 1'b0, 2'd0, 1'b1};
        vec[9]  = '{4'b1111, 8'b0001_1000, 1'b1, 2'd1, 1'b1};
        vec[10] = '{4'b1111, 8'b0000_0001, 1'b1, 2'd1, 1'b1};
        vec[11] = '{4'b1111, 8'b0001_0001, 1'b0, 2'd0, 1'b1};
        vec[12] = '{4'b1111, 8'b0000_0100, 1'b0, 2'd0, 1'b1};
        vec[13] = '{4'b1111, 8'b0000_0010, 1'b0, 2'd0, 1'b1};
        vec[14] = '{4'b1111, 8'b0001_0100, 1'b0, 2'd0, 1'b1};
        vec[15] = '{4'b1111, 8'b0001_0010, 1'b0, 2'd0, 1'b1};

        // Table: granu 0 gives RUN at edge 1 -> DRAIN, evaluation at edge 2.
        granu = 16'd0;
        for (int i = 0; i < 16; i++) begin
            mask = {1'b0, vec[i].mask};
            {br, ibr, rcv, lsf, fel, ildst, fu, agu} = vec[i].occ;
            do_reset();
            tick();
            tick();
            check($sformatf("vec%0d req", i), a_req, vec[i].exp_req);
            check($sformatf("vec%0d to", i), a_to, vec[i].exp_to);
            check($sformatf("vec%0d hold", i), a_hold, vec[i].exp_hold);
            check($sformatf("vec%0d srun", i), a_srun, vec[i].exp_req);
        end
        {br, ibr, rcv, lsf, fel, ildst, fu, agu} = 8'b0;

        // Full rotation 0,1,2,3,0 with granu 3.
        mask = 5'b01111; granu = 16'd3; auto_resp = 1;
        do_reset();
        check("rst sm", a_sm, 0);
        check("rst to", a_to, 0);
        check("rst req", a_req, 0);
        check("rst srun", a_srun, 0);
        check("rst hold", a_hold, 0);
        check("rst tmo", a_tmo, 0);
        fh = -1; first_req = -1; first_to = -1; srun_bad = 0; last_sm = a_sm;
        smq.delete();
        for (int e = 1; e < 300 && smq.size() < 4; e++) begin
            tick();
            if (a_srun !== a_req) srun_bad++;
            if (fh < 0 && a_hold) fh = e;
            if (first_req < 0 && a_req) begin first_req = e; first_to = a_to; end
            if (a_sm !== last_sm) begin smq.push_back(a_sm); last_sm = a_sm; end
        end
        check("rot drain edge", fh, 4);
        check("rot req edge", first_req, 5);
        check("rot first to", first_to, 1);
        check("rot seq len", smq.size(), 4);
        check("rot seq", (smq.size() == 4) ? {smq[0][7:0], smq[1][7:0], smq[2][7:0], smq[3][7:0]} : 32'hffff_ffff,
              32'h01_02_03_00);
        check("rot srun==req", srun_bad, 0);

        // Sparse masks.
        mask = 5'b01111; granu = 16'd1;
        do_reset();
        wait_sm(2'd1, "m1010 reach 1");
        mask = 5'b01010;
        wait_req("m1010 req a");
        check("m1010 to 3", a_to, 3);
        wait_sm(2'd3, "m1010 reach 3");
        wait_req("m1010 req b");
        check("m1010 to 1", a_to, 1);
        wait_sm(2'd1, "m1010 back 1");
        mask = 5'b00010; nreq = 0; nhold = 0;
        repeat (40) begin tick(); nreq += a_req; nhold += a_hold; end
        check("m0010 no req", nreq, 0);
        check("m0010 renewed", nhold > 0, 1);
        check("m0010 sm", a_sm, 1);

        // Branch held 10 cycles in DRAIN.
        mask = 5'b01111; granu = 16'd3;
        do_reset();
        br = 1'b1;
        for (int k = 0; k < 50 && !a_hold; k++) tick();
        check("br drain seen", a_hold, 1);
        bad = 0;
        repeat (10) begin tick(); if (a_hold !== 1'b1 || a_req !== 1'b0) bad++; end
        check("br held drain", bad, 0);
        br = 1'b0;
        tick();
        check("br req rise", a_req, 1);
        check("br to", a_to, 1);

        // Stall pulse mid-quantum, granu 7.
        auto_resp = 0; done = 0; granu = 16'd7;
        do_reset();
        fh = -1;
        for (int e = 1; e <= 40; e++) begin
            stall = (e >= 4 && e <= 8);
            tick();
            if (fh < 0 && a_hold) fh = e;
        end
        stall = 1'b0;
        check("stall drain edge", fh, 13);

        // Reset while swapping.
        granu = 16'd0; auto_resp = 1;
        do_reset();
        wait_sm(2'd1, "rsw reach 1");
        auto_resp = 0; done = 0;
        wait_req("rsw req");
        check("rsw to", a_to, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rsw sm", a_sm, 0);
        check("rsw req0", a_req, 0);
        check("rsw srun", a_srun, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("rsw late done sm", a_sm, 0);
        check("rsw late done req", a_req, 0);

        // Drain watchdog.
        granu = 16'd0; br = 1'b1;
        do_reset();
        tick();
        check("wd drain", a_hold, 1);
`ifdef SM_DRAIN_WDOG_EN
        ntmo = 0;
        repeat (15) begin tick(); ntmo += a_tmo; end
        check("wd early", ntmo, 0);
        tick();
        check("wd fire", a_tmo, 1);
        br = 1'b0; auto_resp = 1;
        wait_sm(2'd1, "wd swap");
        check("wd sticky", a_tmo, 1);
`else
        ntmo = 0;
        repeat (30) begin tick(); ntmo += a_tmo; end
        check("wd tied", ntmo, 0);
        br = 1'b0; auto_resp = 1;
        wait_sm(2'd1, "wd swap");
        check("wd tied after", a_tmo, 0);
`endif
        auto_resp = 0; done = 0;

        // Random traffic on the 5-context instance against a behavioural model.
        do_reset();
        m_ph = 0; m_cnt = 0; m_sm = 0; m_to = 0; m_dc = 0; m_tmo = 0;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            stall = ($urandom_range(0, 4) == 0);
            en    = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 7))
                0:       mask = 5'b0;
                1:       mask = 5'b1 << $urandom_range(0, 4);
                default: mask = 5'($urandom);
            endcase
            granu = 16'($urandom_range(0, 3));
            {br, ibr, rcv, lsf, fel, ildst, fu, agu} = 8'b0;
            if ($urandom_range(0, 2) == 0) {br, ibr, rcv, lsf, fel, ildst, fu, agu} = 8'(1 << $urandom_range(0, 7));
            lsf  = lsf | ($urandom_range(0, 1) == 0);
            done = ($urandom_range(0, 2) == 0);

            if (!reset) begin
                m_ph = 0; m_cnt = 0; m_sm = 0; m_to = 0; m_tmo = 0;
            end else if (m_ph == 0) begin
                if (!en) m_cnt = 0;
                else if (!stall) begin
                    if (m_cnt < granu) m_cnt++;
                    else begin m_ph = 1; m_dc = 0; end
                end
            end else if (m_ph == 1) begin
                m_dc++;
`ifdef SM_DRAIN_WDOG_EN
                if (m_dc >= 16) m_tmo = 1;
`endif
                if (!stall && safe_f()) begin
                    if (next_f(m_sm, mask, 5) == m_sm) begin m_ph = 0; m_cnt = 0; end
                    else begin m_to = next_f(m_sm, mask, 5); m_ph = 2; end
                end
            end else if (done) begin
                m_sm = m_to; m_cnt = 0; m_ph = 0;
            end

            tick();
            got_v = {b_req, b_srun, b_hold, b_sm, b_to, b_from, b_tmo};
            exp_v = {m_ph == 2, m_ph == 2, m_ph != 0, 3'(m_sm), 3'(m_to), 3'(m_sm), m_tmo != 0};
            if (got_v !== exp_v && bad < 5) begin
                bad++;
                check($sformatf("rand cyc%0d {req,srun,hold,sm,to,from,tmo}", c), got_v, exp_v);
            end else if (c % 100 == 0) begin
                check($sformatf("rand cyc%0d {req,srun,hold,sm,to,from,tmo}", c), got_v, exp_v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_slice_scheduler.md
Name: sm_slice_scheduler

Overview:
- Time-slice scheduler that rotates the GPGPU pipeline among up to N_CTX resident SM contexts.
- Counts a per-quantum cycle budget, then drains the pipeline to a safe point: no branch/reconvergence in flight, no load/store in flight.
- Runs a request/done swap handshake with the context-swap engine, then advances round-robin over a runtime enable mask, skipping disabled contexts.
- Sits beside the front end; drives the active-context select (sm_o) and the pipeline run-stall.

Parameters:
- N_CTX, 8, number of schedulable contexts (2..256).
- CTX_LOG, 3, width of context index; must satisfy 2**CTX_LOG >= N_CTX.
- GRAN_W, 16, width of quantum counter and granu_i.
- WAIT_LIMIT, 1024, drain watchdog limit in cycles (used only with SM_DRAIN_WDOG_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- stall_i  in  1  global pipeline stall; freezes quantum counting and drain evaluation.
- en_i  in  1  scheduler enable; low = no rotation.
- ctx_mask_i  in  N_CTX  per-context enable, bit k = context k schedulable.
- granu_i  in  GRAN_W  quantum length minus one.
- branch_i, issuedbranch_i, reconv_i  in  1 each  branch/reconvergence in flight.
- lsuStallFront_i, frontendLdSt_i, issuedLdSt_i, fuLdSt_i, aguLdSt_i  in  1 each  load/store occupancy.
- swapDone_i  in  1  swap engine finished.
- swap_req_o  out  1  swap request, level, held until swapDone_i.
- swap_from_o  out  CTX_LOG  outgoing context (= sm_o).
- swap_to_o  out  CTX_LOG  incoming context, stable while swap_req_o=1.
- sm_o  out  CTX_LOG  active context.
- fetch_hold_o  out  1  blocks new fetch while draining.
- stallRun_o  out  1  run-stall to pipeline during swap.
- drain_timeout_o  out  1  sticky watchdog flag (tied 0 without the feature).

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clk edge) values: sm_o=0, swap_to_o=0, swap_req_o=0, stallRun_o=0, fetch_hold_o=0, drain_timeout_o=0; state=RUN; cnt=0. Reset mid-SWAP aborts the swap with no completion.
- safe = notBraRcv & notLdSt, where:
  - notBraRcv = ~reconv_i & ~issuedbranch_i & ~branch_i
  - notLdSt = lsuStallFront_i ? (~issuedLdSt_i & ~fuLdSt_i & ~aguLdSt_i) : (~frontendLdSt_i & ~issuedLdSt_i & ~fuLdSt_i)
- next = first set bit of ctx_mask_i searching sm_o+1, sm_o+2, ..., wrapping from N_CTX-1 to 0, ending at sm_o inclusive. If mask = 0, next = sm_o.
- RUN:
  - en_i=0: cnt<=0, stay in RUN.
  - stall_i=1: hold cnt.
  - Otherwise, if cnt < granu_i (unsigned, granu_i sampled live): cnt<=cnt+1.
  - Otherwise: go to DRAIN with fetch_hold_o<=1.
  - A quantum is therefore granu_i+1 unstalled cycles; granu_i=0 gives 1 cycle.
- DRAIN:
  - fetch_hold_o=1; cnt holds; stall_i=1 freezes evaluation.
  - On ~stall_i & safe with next==sm_o: cnt<=0, fetch_hold_o<=0, go to RUN (quantum renewed, no swap).
  - On ~stall_i & safe with next!=sm_o: swap_to_o<=next, swap_req_o<=1, stallRun_o<=1, go to SWAP.
  - en_i deasserting in DRAIN does not abort it.
- SWAP:
  - Unaffected by stall_i and en_i.
  - swap_req_o, stallRun_o and fetch_hold_o held at 1.
  - On swapDone_i=1 at an edge: sm_o<=swap_to_o, cnt<=0, and swap_req_o, stallRun_o, fetch_hold_o all <=0; go to RUN.
  - Completion takes effect at the same edge; the first cycle of the new quantum is the following cycle.
  - swapDone_i received already high on SWAP entry completes on the next edge (minimum SWAP dwell = 1 cycle).
- swapDone_i is ignored outside SWAP.
- ctx_mask_i changes take effect only at DRAIN evaluation; swap_to_o is never altered in SWAP.
- Current context masked off: it still runs its quantum, then swaps to the next enabled context.
- Index arithmetic wraps modulo N_CTX, not 2**CTX_LOG.
- The swap_to_o != swap_from_o invariant holds whenever swap_req_o=1.

Optional Feature:
- Macro: SM_DRAIN_WDOG_EN.
- Defined: a cycle counter clears on DRAIN entry and increments every DRAIN cycle, including stalled cycles. On reaching WAIT_LIMIT it sets drain_timeout_o=1, sticky until reset. Scheduling is unchanged; it never forces a swap.
- Undefined: no counter logic; drain_timeout_o tied 0.

Test Plan:
- Reset: N_CTX=4, mask=4'b1111, granu_i=3, safe held, swapDone_i returned 2 cycles after swap_req_o -> 4 RUN cycles, 1 DRAIN cycle, SWAP with swap_to_o=1; sm_o sequence 0,1,2,3,0; stallRun_o=1 only during SWAP.
- mask=4'b1010 from sm_o=1 -> swap_to_o=3, then 1; mask=4'b0010 with sm_o=1 -> quantum renewed, swap_req_o never asserts.
- Hold branch_i=1 for 10 cycles after quantum expiry -> fetch_hold_o=1 for those cycles; swap_req_o rises 1 cycle after branch_i falls.
- stall_i pulsed for 5 cycles mid-quantum, granu_i=7 -> DRAIN entered after exactly 8 unstalled RUN cycles.
- Reset asserted while swap_req_o=1 -> next cycle sm_o=0, swap_req_o=0, stallRun_o=0; a later swapDone_i pulse is ignored.
- With SM_DRAIN_WDOG_EN, WAIT_LIMIT=16, safe held low -> drain_timeout_o rises after 16 DRAIN cycles and stays 1 after safe returns and the swap completes.
